// File: rtl/crop_pkg.sv
// Shared definitions for the crop-stage configuration scheduler: shadow bank
// addresses, scheduler states, the crop window record and stream bit indices.
package crop_pkg;

   // Shadow register bank addresses; address 7 is reserved.
   localparam logic [2:0] ADDR_CTRL  = 3'd0;
   localparam logic [2:0] ADDR_IN_X  = 3'd1;
   localparam logic [2:0] ADDR_IN_Y  = 3'd2;
   localparam logic [2:0] ADDR_OFF_X = 3'd3;
   localparam logic [2:0] ADDR_OFF_Y = 3'd4;
   localparam logic [2:0] ADDR_OUT_X = 3'd5;
   localparam logic [2:0] ADDR_OUT_Y = 3'd6;

   // Frame-start flag within the stream user field, crop enable within ctrl.
   localparam int FS_BIT      = 1;
   localparam int CROP_EN_BIT = 7;

   typedef enum logic {
      IDLE,
      ARMED
   } state_t;

   typedef struct packed {
      logic [15:0] in_x;
      logic [15:0] in_y;
      logic [15:0] off_x;
      logic [15:0] off_y;
      logic [15:0] out_x;
      logic [15:0] out_y;
   } crop_win_t;

   function automatic logic [16:0] min17(input logic [16:0] a, input logic [16:0] b);
      return (a < b) ? a : b;
   endfunction

endpackage

// File: rtl/crop_win_clamp.sv
// Combinational crop window clamp: fits the requested crop size inside the
// input frame after the offset. An offset outside the frame disables the crop.
module crop_win_clamp
   import crop_pkg::*;
(
   input  crop_win_t win,
   output crop_win_t clamped,
   output logic      clamp_flag,
   output logic      disable_flag
);

   logic [16:0] rem_x, rem_y;
   logic [16:0] want_x, want_y;
   logic [16:0] fit_x, fit_y;

   // Compute remaining room per axis and the fitted crop size (17-bit, no wrap).
   always_comb begin
      // NOTE: every output of a combinational block gets a default first so no latch is inferred.
      clamped      = win;
      clamp_flag   = 1'b0;
      disable_flag = 1'b0;

      rem_x  = {1'b0, win.in_x} - {1'b0, win.off_x};
      rem_y  = {1'b0, win.in_y} - {1'b0, win.off_y};
      // A requested size of zero means "whatever is left after the offset".
      want_x = (win.out_x == 16'd0) ? rem_x : {1'b0, win.out_x};
      want_y = (win.out_y == 16'd0) ? rem_y : {1'b0, win.out_y};
      fit_x  = min17(want_x, rem_x);
      fit_y  = min17(want_y, rem_y);

      if (({1'b0, win.off_x} >= {1'b0, win.in_x}) || ({1'b0, win.off_y} >= {1'b0, win.in_y})) begin
         disable_flag  = 1'b1;
         clamp_flag    = 1'b1;
         clamped.out_x = 16'd0;
         clamped.out_y = 16'd0;
      end else begin
         clamped.out_x = fit_x[15:0];
         clamped.out_y = fit_y[15:0];
         clamp_flag    = (fit_x != {1'b0, win.out_x}) || (fit_y != {1'b0, win.out_y});
      end
   end

endmodule

// File: rtl/crop_cfg_sched.sv
// Frame-synchronous configuration scheduler for the ISP crop stage. The host
// fills a shadow bank and commits; the clamped window is applied on a chosen
// frame start so the crop never changes mid-frame.
// Optional: define CROP_CFG_TIMEOUT_EN to force an apply after TIMEOUT cycles
// in ARMED without a frame start.
module crop_cfg_sched
   import crop_pkg::*;
#(
   parameter logic [15:0] DEF_IN_X = 16'd1920,
   parameter logic [15:0] DEF_IN_Y = 16'd1080,
   parameter logic [23:0] TIMEOUT  = 24'd8000000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        cfg_wr_en,
   input  logic [2:0]  cfg_addr,
   input  logic [15:0] cfg_wr_data,
   input  logic        cfg_commit,
   input  logic [3:0]  cfg_skip,
   input  logic        cfg_err_clr,
   output logic        cfg_busy,
   output logic        cfg_applied,
   output logic [1:0]  cfg_error,
   input  logic        mon_valid,
   input  logic        mon_ready,
   input  logic [7:0]  mon_user,
   output logic [15:0] frame_cnt,
   output logic [15:0] isp_ctrl,
   output logic [15:0] isp_in_pixel_x,
   output logic [15:0] isp_in_pixel_y,
   output logic [15:0] isp_out_offset_x,
   output logic [15:0] isp_out_offset_y,
   output logic [15:0] isp_out_pixel_x,
   output logic [15:0] isp_out_pixel_y
);

   localparam crop_win_t DEF_WIN = '{DEF_IN_X, DEF_IN_Y, 16'd0, 16'd0, DEF_IN_X, DEF_IN_Y};

   state_t      state;
   logic [3:0]  skip_cnt;
   logic [15:0] sh_ctrl;
   crop_win_t   sh_win;
   logic [15:0] act_ctrl;
   crop_win_t   act_win;
   crop_win_t   clamped_win;
   logic        win_clamped;
   logic        win_disabled;
   logic        fs;
   logic        timeout_hit;
   logic        do_apply;
   logic [1:0]  err_set;
   logic        unused_user;

   assign fs          = mon_valid & mon_ready & mon_user[FS_BIT];
   assign unused_user = ^{mon_user[7:2], mon_user[0]};

`ifdef CROP_CFG_TIMEOUT_EN
   logic [23:0] to_cnt;

   // Count ARMED cycles since entry or the last frame start.
   always_ff @(posedge clk) begin
      if (reset) begin
         to_cnt <= 24'd0;
      end else if ((state == IDLE) || fs) begin
         to_cnt <= 24'd0;
      end else begin
         to_cnt <= to_cnt + 24'd1;
      end
   end

   assign timeout_hit = (state == ARMED) && !fs && (to_cnt == TIMEOUT - 24'd1);
`else
   assign timeout_hit = 1'b0;
`endif

   assign do_apply = (state == ARMED) && ((fs && (skip_cnt == 4'd0)) || timeout_hit);
   assign err_set  = {(state == ARMED) && (cfg_wr_en || cfg_commit), do_apply && win_clamped};

   crop_win_clamp u_clamp (
      .win          (sh_win),
      .clamped      (clamped_win),
      .clamp_flag   (win_clamped),
      .disable_flag (win_disabled)
   );

   // Shadow bank: host writes land only while no commit is pending.
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      if (reset) begin
         sh_ctrl <= 16'd0;
         sh_win  <= DEF_WIN;
      end else if ((state == IDLE) && cfg_wr_en) begin
         case (cfg_addr)
            ADDR_CTRL:  sh_ctrl      <= cfg_wr_data;
            ADDR_IN_X:  sh_win.in_x  <= cfg_wr_data;
            ADDR_IN_Y:  sh_win.in_y  <= cfg_wr_data;
            ADDR_OFF_X: sh_win.off_x <= cfg_wr_data;
            ADDR_OFF_Y: sh_win.off_y <= cfg_wr_data;
            ADDR_OUT_X: sh_win.out_x <= cfg_wr_data;
            ADDR_OUT_Y: sh_win.out_y <= cfg_wr_data;
            default:    ;
         endcase
      end
   end

   // Accepted frame starts, counted in every state; wraps naturally.
   always_ff @(posedge clk) begin
      if (reset) begin
         frame_cnt <= 16'd0;
      end else if (fs) begin
         frame_cnt <= frame_cnt + 16'd1;
      end
   end

   // Scheduler FSM with registered apply, pulse and sticky error flags.
   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= IDLE;
         skip_cnt    <= 4'd0;
         act_ctrl    <= 16'd0;
         act_win     <= DEF_WIN;
         cfg_applied <= 1'b0;
         cfg_error   <= 2'b00;
      end else begin
         cfg_applied <= do_apply;
         // A set event in the same cycle as a clear wins.
         cfg_error   <= (cfg_err_clr ? 2'b00 : cfg_error) | err_set;

         if (do_apply) begin
            act_ctrl <= sh_ctrl;
            if (win_disabled) begin
               act_ctrl[CROP_EN_BIT] <= 1'b0;
            end
            act_win <= clamped_win;
         end

         case (state)
            IDLE: begin
               if (cfg_commit) begin
                  skip_cnt <= cfg_skip;
                  state    <= ARMED;
               end
            end
            ARMED: begin
               if (do_apply) begin
                  state <= IDLE;
               end else if (fs && (skip_cnt != 4'd0)) begin
                  skip_cnt <= skip_cnt - 4'd1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign cfg_busy         = (state == ARMED);
   assign isp_ctrl         = act_ctrl;
   assign isp_in_pixel_x   = act_win.in_x;
   assign isp_in_pixel_y   = act_win.in_y;
   assign isp_out_offset_x = act_win.off_x;
   assign isp_out_offset_y = act_win.off_y;
   assign isp_out_pixel_x  = act_win.out_x;
   assign isp_out_pixel_y  = act_win.out_y;

endmodule

// File: tb/tb_crop_cfg_sched.sv
// Directed bench for crop_cfg_sched: reset state, commit/apply timing, frame
// skipping, window clamping, dropped writes, stream gating, reset while armed,
// frame counter wrap and the (optional) ARMED timeout.
module tb_crop_cfg_sched;

   logic        clk = 1'b0;
   logic        reset;
   logic        cfg_wr_en;
   logic [2:0]  cfg_addr;
   logic [15:0] cfg_wr_data;
   logic        cfg_commit;
   logic [3:0]  cfg_skip;
   logic        cfg_err_clr;
   logic        cfg_busy;
   logic        cfg_applied;
   logic [1:0]  cfg_error;
   logic        mon_valid;
   logic        mon_ready;
   logic [7:0]  mon_user;
   logic [15:0] frame_cnt;
   logic [15:0] isp_ctrl;
   logic [15:0] isp_in_pixel_x, isp_in_pixel_y;
   logic [15:0] isp_out_offset_x, isp_out_offset_y;
   logic [15:0] isp_out_pixel_x, isp_out_pixel_y;

   int n_cmp = 0;
   int n_bad = 0;

   logic [95:0] act_win;
   assign act_win = {isp_in_pixel_x, isp_in_pixel_y, isp_out_offset_x,
                     isp_out_offset_y, isp_out_pixel_x, isp_out_pixel_y};

   always #5 clk = ~clk;

   crop_cfg_sched #(.TIMEOUT(24'd100)) dut (
      .clk              (clk),
      .reset            (reset),
      .cfg_wr_en        (cfg_wr_en),
      .cfg_addr         (cfg_addr),
      .cfg_wr_data      (cfg_wr_data),
      .cfg_commit       (cfg_commit),
      .cfg_skip         (cfg_skip),
      .cfg_err_clr      (cfg_err_clr),
      .cfg_busy         (cfg_busy),
      .cfg_applied      (cfg_applied),
      .cfg_error        (cfg_error),
      .mon_valid        (mon_valid),
      .mon_ready        (mon_ready),
      .mon_user         (mon_user),
      .frame_cnt        (frame_cnt),
      .isp_ctrl         (isp_ctrl),
      .isp_in_pixel_x   (isp_in_pixel_x),
      .isp_in_pixel_y   (isp_in_pixel_y),
      .isp_out_offset_x (isp_out_offset_x),
      .isp_out_offset_y (isp_out_offset_y),
      .isp_out_pixel_x  (isp_out_pixel_x),
      .isp_out_pixel_y  (isp_out_pixel_y)
   );

   // Inputs change 1 time unit after a rising edge; outputs are read there too.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      step();
      step();
      reset = 1'b0;
      step();
   endtask

   task automatic wr(input logic [2:0] a, input logic [15:0] d);
      cfg_wr_en   = 1'b1;
      cfg_addr    = a;
      cfg_wr_data = d;
      step();
      cfg_wr_en   = 1'b0;
   endtask

   task automatic commit(input logic [3:0] s);
      cfg_commit = 1'b1;
      cfg_skip   = s;
      step();
      cfg_commit = 1'b0;
   endtask

   task automatic stream(input logic v, input logic r, input logic [7:0] u);
      mon_valid = v;
      mon_ready = r;
      mon_user  = u;
      step();
      mon_valid = 1'b0;
      mon_ready = 1'b0;
      mon_user  = 8'h00;
   endtask

   task automatic err_clr();
      cfg_err_clr = 1'b1;
      step();
      cfg_err_clr = 1'b0;
   endtask

   task automatic test_reset();
      logic [95:0] ew;
      do_reset();
      ew = {16'd1920, 16'd1080, 16'd0, 16'd0, 16'd1920, 16'd1080};
      n_cmp++; if (act_win !== ew) begin n_bad++; $display("FAIL reset_win: got %h want %h", act_win, ew); end
      n_cmp++; if (isp_ctrl !== 16'h0000) begin n_bad++; $display("FAIL reset_ctrl: got %h want 0000", isp_ctrl); end
      n_cmp++; if ({cfg_busy, cfg_applied, cfg_error} !== 4'b0000) begin n_bad++; $display("FAIL reset_flags: got %b want 0000", {cfg_busy, cfg_applied, cfg_error}); end
      n_cmp++; if (frame_cnt !== 16'd0) begin n_bad++; $display("FAIL reset_frame_cnt: got %0d want 0", frame_cnt); end
   endtask

   task automatic test_basic_apply();
      logic [95:0] ew;
      wr(3'd1, 16'd640);
      wr(3'd2, 16'd480);
      wr(3'd3, 16'd16);
      wr(3'd4, 16'd8);
      wr(3'd5, 16'd320);
      wr(3'd6, 16'd240);
      wr(3'd0, 16'h0181);
      wr(3'd7, 16'hFFFF);
      commit(4'd0);
      n_cmp++; if (cfg_busy !== 1'b1) begin n_bad++; $display("FAIL basic_busy: got %b want 1", cfg_busy); end
      n_cmp++; if (isp_in_pixel_x !== 16'd1920) begin n_bad++; $display("FAIL basic_pre_apply: got %0d want 1920", isp_in_pixel_x); end
      stream(1'b1, 1'b1, 8'h02);
      ew = {16'd640, 16'd480, 16'd16, 16'd8, 16'd320, 16'd240};
      n_cmp++; if (act_win !== ew) begin n_bad++; $display("FAIL basic_win: got %h want %h", act_win, ew); end
      n_cmp++; if (isp_ctrl !== 16'h0181) begin n_bad++; $display("FAIL basic_ctrl: got %h want 0181", isp_ctrl); end
      n_cmp++; if ({cfg_busy, cfg_applied, cfg_error} !== 4'b0100) begin n_bad++; $display("FAIL basic_flags: got %b want 0100", {cfg_busy, cfg_applied, cfg_error}); end
      n_cmp++; if (frame_cnt !== 16'd1) begin n_bad++; $display("FAIL basic_frame_cnt: got %0d want 1", frame_cnt); end
      step();
      n_cmp++; if (cfg_applied !== 1'b0) begin n_bad++; $display("FAIL basic_pulse_width: got %b want 0", cfg_applied); end
   endtask

   task automatic test_skip();
      logic [95:0] ew;
      do_reset();
      wr(3'd1, 16'd640);
      wr(3'd2, 16'd480);
      wr(3'd5, 16'd320);
      wr(3'd6, 16'd240);
      commit(4'd2);
      for (int i = 1; i <= 2; i++) begin
         stream(1'b1, 1'b1, 8'h02);
         n_cmp++; if ({cfg_busy, cfg_applied, isp_in_pixel_x} !== {2'b10, 16'd1920}) begin n_bad++; $display("FAIL skip_hold_%0d: got %b/%b/%0d want 1/0/1920", i, cfg_busy, cfg_applied, isp_in_pixel_x); end
         n_cmp++; if (frame_cnt !== 16'(i)) begin n_bad++; $display("FAIL skip_cnt_%0d: got %0d want %0d", i, frame_cnt, i); end
      end
      stream(1'b1, 1'b1, 8'h02);
      ew = {16'd640, 16'd480, 16'd0, 16'd0, 16'd320, 16'd240};
      n_cmp++; if (act_win !== ew) begin n_bad++; $display("FAIL skip_win: got %h want %h", act_win, ew); end
      n_cmp++; if ({cfg_busy, cfg_applied, cfg_error} !== 4'b0100) begin n_bad++; $display("FAIL skip_flags: got %b want 0100", {cfg_busy, cfg_applied, cfg_error}); end
      n_cmp++; if (frame_cnt !== 16'd3) begin n_bad++; $display("FAIL skip_frame_cnt: got %0d want 3", frame_cnt); end
   endtask

   task automatic test_clamp();
      logic [95:0] ew;
      wr(3'd0, 16'h0081);
      wr(3'd3, 16'd600);
      wr(3'd5, 16'd100);
      commit(4'd0);
      stream(1'b1, 1'b1, 8'h02);
      ew = {16'd640, 16'd480, 16'd600, 16'd0, 16'd40, 16'd240};
      n_cmp++; if (act_win !== ew) begin n_bad++; $display("FAIL clamp_reduce_win: got %h want %h", act_win, ew); end
      n_cmp++; if (cfg_error !== 2'b01) begin n_bad++; $display("FAIL clamp_reduce_err: got %b want 01", cfg_error); end
      n_cmp++; if (isp_ctrl !== 16'h0081) begin n_bad++; $display("FAIL clamp_reduce_ctrl: got %h want 0081", isp_ctrl); end
      err_clr();
      n_cmp++; if (cfg_error !== 2'b00) begin n_bad++; $display("FAIL clamp_err_clr: got %b want 00", cfg_error); end
      wr(3'd3, 16'd640);
      commit(4'd0);
      stream(1'b1, 1'b1, 8'h02);
      ew = {16'd640, 16'd480, 16'd640, 16'd0, 16'd0, 16'd0};
      n_cmp++; if (act_win !== ew) begin n_bad++; $display("FAIL clamp_bypass_win: got %h want %h", act_win, ew); end
      n_cmp++; if (isp_ctrl !== 16'h0001) begin n_bad++; $display("FAIL clamp_bypass_ctrl: got %h want 0001", isp_ctrl); end
      n_cmp++; if (cfg_error !== 2'b01) begin n_bad++; $display("FAIL clamp_bypass_err: got %b want 01", cfg_error); end
      err_clr();
      wr(3'd3, 16'd100);
      wr(3'd5, 16'd0);
      commit(4'd0);
      stream(1'b1, 1'b1, 8'h02);
      ew = {16'd640, 16'd480, 16'd100, 16'd0, 16'd540, 16'd240};
      n_cmp++; if (act_win !== ew) begin n_bad++; $display("FAIL clamp_zero_win: got %h want %h", act_win, ew); end
      n_cmp++; if ({isp_ctrl, cfg_error} !== {16'h0081, 2'b01}) begin n_bad++; $display("FAIL clamp_zero_ctrl_err: got %h/%b want 0081/01", isp_ctrl, cfg_error); end
      err_clr();
   endtask

   task automatic test_armed_drop();
      logic [95:0] ew;
      wr(3'd5, 16'd200);
      // Write and commit in the same cycle: the write is part of the commit.
      cfg_wr_en = 1'b1; cfg_addr = 3'd0; cfg_wr_data = 16'h0181;
      cfg_commit = 1'b1; cfg_skip = 4'd0;
      step();
      cfg_wr_en = 1'b0; cfg_commit = 1'b0;
      n_cmp++; if ({cfg_busy, cfg_error} !== 3'b100) begin n_bad++; $display("FAIL drop_commit_state: got %b want 100", {cfg_busy, cfg_error}); end
      wr(3'd0, 16'h1234);
      n_cmp++; if (cfg_error !== 2'b10) begin n_bad++; $display("FAIL drop_write_err: got %b want 10", cfg_error); end
      cfg_err_clr = 1'b1;
      wr(3'd6, 16'd16);
      cfg_err_clr = 1'b0;
      n_cmp++; if (cfg_error !== 2'b10) begin n_bad++; $display("FAIL drop_set_wins: got %b want 10", cfg_error); end
      err_clr();
      n_cmp++; if (cfg_error !== 2'b00) begin n_bad++; $display("FAIL drop_clr: got %b want 00", cfg_error); end
      stream(1'b1, 1'b1, 8'h02);
      ew = {16'd640, 16'd480, 16'd100, 16'd0, 16'd200, 16'd240};
      n_cmp++; if (act_win !== ew) begin n_bad++; $display("FAIL drop_win: got %h want %h", act_win, ew); end
      n_cmp++; if ({isp_ctrl, cfg_applied, cfg_error} !== {16'h0181, 3'b100}) begin n_bad++; $display("FAIL drop_ctrl_flags: got %h/%b/%b want 0181/1/00", isp_ctrl, cfg_applied, cfg_error); end
      n_cmp++; if (frame_cnt !== 16'd7) begin n_bad++; $display("FAIL drop_frame_cnt: got %0d want 7", frame_cnt); end
   endtask

   task automatic test_stream_gating();
      commit(4'd0);
      stream(1'b1, 1'b0, 8'h02);
      n_cmp++; if ({frame_cnt, cfg_busy, cfg_applied} !== {16'd7, 2'b10}) begin n_bad++; $display("FAIL gate_not_ready: got %0d/%b/%b want 7/1/0", frame_cnt, cfg_busy, cfg_applied); end
      stream(1'b1, 1'b1, 8'h01);
      n_cmp++; if ({frame_cnt, cfg_busy, cfg_applied} !== {16'd7, 2'b10}) begin n_bad++; $display("FAIL gate_no_fs_bit: got %0d/%b/%b want 7/1/0", frame_cnt, cfg_busy, cfg_applied); end
      stream(1'b0, 1'b1, 8'h02);
      n_cmp++; if ({frame_cnt, cfg_busy, cfg_applied} !== {16'd7, 2'b10}) begin n_bad++; $display("FAIL gate_not_valid: got %0d/%b/%b want 7/1/0", frame_cnt, cfg_busy, cfg_applied); end
   endtask

   task automatic test_reset_armed();
      logic [95:0] ew;
      ew = {16'd1920, 16'd1080, 16'd0, 16'd0, 16'd1920, 16'd1080};
      reset = 1'b1;
      step();
      reset = 1'b0;
      step();
      n_cmp++; if ({cfg_busy, cfg_error, frame_cnt} !== {3'b000, 16'd0}) begin n_bad++; $display("FAIL rst_armed_state: got %b/%b/%0d want 0/00/0", cfg_busy, cfg_error, frame_cnt); end
      n_cmp++; if ({act_win, isp_ctrl} !== {ew, 16'h0000}) begin n_bad++; $display("FAIL rst_armed_win: got %h/%h want %h/0000", act_win, isp_ctrl, ew); end
      stream(1'b1, 1'b1, 8'h02);
      n_cmp++; if ({frame_cnt, cfg_busy, cfg_applied} !== {16'd1, 2'b00}) begin n_bad++; $display("FAIL rst_armed_no_pending: got %0d/%b/%b want 1/0/0", frame_cnt, cfg_busy, cfg_applied); end
      n_cmp++; if (act_win !== ew) begin n_bad++; $display("FAIL rst_armed_win_held: got %h want %h", act_win, ew); end
   endtask

   task automatic test_frame_wrap();
      mon_valid = 1'b1; mon_ready = 1'b1; mon_user = 8'h02;
      repeat (65534) step();
      n_cmp++; if (frame_cnt !== 16'd65535) begin n_bad++; $display("FAIL wrap_max: got %0d want 65535", frame_cnt); end
      step();
      mon_valid = 1'b0; mon_ready = 1'b0; mon_user = 8'h00;
      n_cmp++; if (frame_cnt !== 16'd0) begin n_bad++; $display("FAIL wrap_zero: got %0d want 0", frame_cnt); end
   endtask

   task automatic test_timeout();
      commit(4'd3);
`ifdef CROP_CFG_TIMEOUT_EN
      repeat (99) step();
      n_cmp++; if ({cfg_busy, cfg_applied} !== 2'b10) begin n_bad++; $display("FAIL timeout_early: got %b want 10", {cfg_busy, cfg_applied}); end
      step();
      n_cmp++; if ({cfg_busy, cfg_applied} !== 2'b01) begin n_bad++; $display("FAIL timeout_apply: got %b want 01", {cfg_busy, cfg_applied}); end
`else
      repeat (1000) step();
      n_cmp++; if ({cfg_busy, cfg_applied} !== 2'b10) begin n_bad++; $display("FAIL no_timeout_busy: got %b want 10", {cfg_busy, cfg_applied}); end
`endif
   endtask

   initial begin
      reset = 1'b0;
      cfg_wr_en = 1'b0; cfg_addr = 3'd0; cfg_wr_data = 16'd0;
      cfg_commit = 1'b0; cfg_skip = 4'd0; cfg_err_clr = 1'b0;
      mon_valid = 1'b0; mon_ready = 1'b0; mon_user = 8'h00;
      test_reset();
      test_basic_apply();
      test_skip();
      test_clamp();
      test_armed_drop();
      test_stream_gating();
      test_reset_armed();
      test_frame_wrap();
      test_timeout();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
